mm_seq: RTL and testbench

- DUT-side responder for the dut_valid/dut_ready handshake.
- Sequences SRAM reads for one matrix multiply, C = A x B.
  - A comes from the input SRAM, B from the weight SRAM.
  - Operand pairs are streamed to an external floating-point MAC (fp_mac, owned separately).
  - Each accumulated element is written to the result SRAM.
- Instantiated inside MyDesign, between the top-level control pins and the three SRAM ports.

---
 rtl/mm_pkg.sv | 14 +
 rtl/mm_addr_gen.sv | 85 ++++++++
 rtl/mm_seq.sv | 114 +++++++++++
 tb/tb_mm_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, types and dimension-word field positions for mm_seq.
package mm_pkg;
   localparam int MM_ADDR_W = 12;
   localparam int MM_DATA_W = 32;
   localparam int MM_DIM_W  = 16;
   localparam int DIM_ROWS_MSB = 31;
   localparam int DIM_ROWS_LSB = 16;
   localparam int DIM_COLS_MSB = 15;
   localparam int DIM_COLS_LSB = 0;
   typedef logic [MM_DIM_W-1:0]  dim_t;
   typedef logic [MM_ADDR_W-1:0] addr_t;
   typedef logic [MM_DATA_W-1:0] data_t;
   typedef enum logic [2:0] {IDLE, DIM, STREAM, WAIT_ACC, WRITE, DONE} mm_state_e;
endpackage

// File: rtl/mm_addr_gen.sv
// mm_addr_gen: i/j/k loop counters and running A/B/C word pointers for one job.
module mm_addr_gen
   import mm_pkg::*;
#(
   parameter int ADDR_W = MM_ADDR_W,
   parameter int DIM_W  = MM_DIM_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              step_i,
   input  logic              next_elem_i,
   input  logic [DIM_W-1:0]  m_i,
   input  logic [DIM_W-1:0]  k_i,
   input  logic [DIM_W-1:0]  n_i,
   output logic [ADDR_W-1:0] a_addr_o,
   output logic [ADDR_W-1:0] b_addr_o,
   output logic [ADDR_W-1:0] c_addr_o,
   output logic              first_o,
   output logic              last_o,
   output logic              done_o
);
   logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kk_q, kk_d;
   logic [ADDR_W-1:0] a_base_q, a_base_d, a_q, a_d, b_q, b_d, c_q, c_d;
   logic              row_end;

   assign row_end  = j_q == n_i - DIM_W'(1);
   assign first_o  = kk_q == '0;
   assign last_o   = kk_q == k_i - DIM_W'(1);
   assign done_o   = row_end && i_q == m_i - DIM_W'(1);
   assign a_addr_o = a_q;
   assign b_addr_o = b_q;
   assign c_addr_o = c_q;

   // A/B/C data start at word 1/1/0; row and column bases are rebuilt by addition only
   always_comb begin
      i_d      = i_q;
      j_d      = j_q;
      kk_d     = kk_q;
      a_base_d = a_base_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      if (start_i) begin
         i_d      = '0;
         j_d      = '0;
         kk_d     = '0;
         a_base_d = ADDR_W'(1);
         a_d      = ADDR_W'(1);
         b_d      = ADDR_W'(1);
         c_d      = '0;
      end else if (step_i) begin
         kk_d = last_o ? '0 : kk_q + DIM_W'(1);
         a_d  = a_q + ADDR_W'(1);
         b_d  = b_q + ADDR_W'(n_i);
      end else if (next_elem_i) begin
         j_d      = row_end ? '0 : j_q + DIM_W'(1);
         i_d      = row_end ? i_q + DIM_W'(1) : i_q;
         a_base_d = row_end ? a_base_q + ADDR_W'(k_i) : a_base_q;
         a_d      = a_base_d;
         b_d      = ADDR_W'(1) + ADDR_W'(j_d);
         c_d      = c_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_q      <= '0;
         j_q      <= '0;
         kk_q     <= '0;
         a_base_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
      end else begin
         i_q      <= i_d;
         j_q      <= j_d;
         kk_q     <= kk_d;
         a_base_q <= a_base_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
      end
   end
endmodule

// File: rtl/mm_seq.sv
// mm_seq: sequences SRAM reads, MAC operand streaming and result writes for one C = A x B job.
module mm_seq
   import mm_pkg::*;
#(
   parameter int ADDR_W = MM_ADDR_W,
   parameter int DATA_W = MM_DATA_W,
   parameter int DIM_W  = MM_DIM_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dut_valid,
   output logic              dut_ready,
   output logic [ADDR_W-1:0] dut__tb__sram_input_read_address,
   input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
   output logic [ADDR_W-1:0] dut__tb__sram_weight_read_address,
   input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
   output logic              dut__tb__sram_result_write_enable,
   output logic [ADDR_W-1:0] dut__tb__sram_result_write_address,
   output logic [DATA_W-1:0] dut__tb__sram_result_write_data,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   input  logic              acc_done,
   input  logic [DATA_W-1:0] acc_data,
   output logic              dim_err
);
   mm_state_e         state_q, state_d;
   logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d, kb;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
   logic              valid_q, first_q, last_q, err_q;
   logic              in_dim, zero_dim, mismatch, start, step, next_elem, first, last, done;

   assign in_dim    = state_q == DIM;
   assign m_d       = in_dim ? DIM_W'(tb__dut__sram_input_read_data[DIM_ROWS_MSB:DIM_ROWS_LSB]) : m_q;
   assign k_d       = in_dim ? DIM_W'(tb__dut__sram_input_read_data[DIM_COLS_MSB:DIM_COLS_LSB]) : k_q;
   assign n_d       = in_dim ? DIM_W'(tb__dut__sram_weight_read_data[DIM_COLS_MSB:DIM_COLS_LSB]) : n_q;
   assign kb        = DIM_W'(tb__dut__sram_weight_read_data[DIM_ROWS_MSB:DIM_ROWS_LSB]);
   assign zero_dim  = m_d == '0 || k_d == '0 || n_d == '0;
   assign mismatch  = kb != k_d;
   assign start     = in_dim && !zero_dim && !mismatch;
   assign step      = state_q == STREAM;
   assign next_elem = state_q == WRITE;
   assign sum_d     = (state_q == WAIT_ACC && acc_done) ? acc_data : sum_q;

   mm_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (start),
      .step_i      (step),
      .next_elem_i (next_elem),
      .m_i         (m_q),
      .k_i         (k_q),
      .n_i         (n_q),
      .a_addr_o    (a_addr),
      .b_addr_o    (b_addr),
      .c_addr_o    (c_addr),
      .first_o     (first),
      .last_o      (last),
      .done_o      (done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = (dut_valid && dut_ready) ? DIM : IDLE;
         DIM:      state_d = start ? STREAM : DONE;
         STREAM:   state_d = last ? WAIT_ACC : STREAM;
         WAIT_ACC: state_d = acc_done ? WRITE : WAIT_ACC;
         WRITE:    state_d = done ? DONE : STREAM;
         default:  state_d = IDLE;
      endcase
   end

   // Issue flags are delayed one cycle so they line up with the SRAM read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         k_q     <= '0;
         n_q     <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         k_q     <= k_d;
         n_q     <= n_d;
         sum_q   <= sum_d;
         valid_q <= step;
         first_q <= step && first;
         last_q  <= step && last;
         err_q   <= in_dim && mismatch;
      end
   end

   assign dut_ready                          = state_q == IDLE;
   assign dut__tb__sram_input_read_address   = dut_ready ? '0 : a_addr;
   assign dut__tb__sram_weight_read_address  = dut_ready ? '0 : b_addr;
   assign dut__tb__sram_result_write_enable  = next_elem;
   assign dut__tb__sram_result_write_address = c_addr;
   assign dut__tb__sram_result_write_data    = sum_q;
   assign mac_valid                          = valid_q;
   assign mac_first                          = first_q;
   assign mac_last                           = last_q;
   assign mac_a                              = valid_q ? tb__dut__sram_input_read_data : '0;
   assign mac_b                              = valid_q ? tb__dut__sram_weight_read_data : '0;
   assign dim_err                            = err_q;
endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: SRAM and fp MAC models around mm_seq with a queue-based write/operand scoreboard.
module tb_mm_seq;
   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;
   typedef struct packed {
      logic [11:0] a;
      logic [11:0] b;
      logic        f;
      logic        l;
      logic [31:0] ad;
      logic [31:0] bd;
   } tr_t;

   logic        clk = 1'b0;
   logic        reset_n, dut_valid, dut_ready;
   logic [11:0] in_addr, w_addr, r_addr;
   logic [31:0] in_rd, w_rd, r_data, mac_a, mac_b, acc_data;
   logic        r_we, mac_valid, mac_first, mac_last, acc_done, dim_err;
   logic [31:0] in_mem [0:4095];
   logic [31:0] w_mem  [0:4095];
   logic [31:0] res_mem[0:4095];
   int          a_v[64];
   int          b_v[64];
   wr_t         wr_q[$];
   tr_t         tr_q[$];
   int          checks = 0, errors = 0, wr_cnt = 0, err_cnt = 0;
   real         acc;
   logic [2:0]  p_done;
   logic [31:0] p_dat[3];

   mm_seq dut (
      .clk                                (clk),
      .reset_n                            (reset_n),
      .dut_valid                          (dut_valid),
      .dut_ready                          (dut_ready),
      .dut__tb__sram_input_read_address   (in_addr),
      .tb__dut__sram_input_read_data      (in_rd),
      .dut__tb__sram_weight_read_address  (w_addr),
      .tb__dut__sram_weight_read_data     (w_rd),
      .dut__tb__sram_result_write_enable  (r_we),
      .dut__tb__sram_result_write_address (r_addr),
      .dut__tb__sram_result_write_data    (r_data),
      .mac_valid                          (mac_valid),
      .mac_first                          (mac_first),
      .mac_last                           (mac_last),
      .mac_a                              (mac_a),
      .mac_b                              (mac_b),
      .acc_done                           (acc_done),
      .acc_data                           (acc_data),
      .dim_err                            (dim_err)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] i2f(input int v);
      int p;
      logic [31:0] u;
      if (v == 0) return 32'h0;
      p = 0;
      for (int b = 0; b < 24; b++) if (v >= (1 << b)) p = b;
      u = 32'(v) << (23 - p);
      return {1'b0, 8'(127 + p), u[22:0]};
   endfunction

   function automatic real f2r(input logic [31:0] f);
      real r;
      int  e;
      if (f[30:0] == 31'h0) return 0.0;
      r = 1.0 + real'(f[22:0]) / 8388608.0;
      e = int'(f[30:23]) - 127;
      for (int x = 0; x < e; x++) r = r * 2.0;
      for (int x = e; x < 0; x++) r = r / 2.0;
      return f[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic real mac_sum(input logic f, input real a0, input logic [31:0] a, input logic [31:0] b);
      return (f ? 0.0 : a0) + f2r(a) * f2r(b);
   endfunction

   // SRAMs: one-cycle read latency, write on the clock edge
   always @(posedge clk) begin
      in_rd <= in_mem[in_addr];
      w_rd  <= w_mem[w_addr];
      if (r_we) res_mem[r_addr] <= r_data;
   end

   // Behavioural MAC: acc_done arrives three cycles after the mac_last term
   always @(posedge clk) begin
      if (!reset_n) begin
         acc    <= 0.0;
         p_done <= 3'b0;
         p_dat[0] <= 32'h0;
         p_dat[1] <= 32'h0;
         p_dat[2] <= 32'h0;
      end else begin
         if (mac_valid) acc <= mac_sum(mac_first, acc, mac_a, mac_b);
         p_done   <= {p_done[1:0], mac_valid && mac_last};
         p_dat[0] <= r2f(mac_sum(mac_first, acc, mac_a, mac_b));
         p_dat[1] <= p_dat[0];
         p_dat[2] <= p_dat[1];
      end
   end
   assign acc_done = p_done[2];
   assign acc_data = p_dat[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compares every result write and every MAC operand beat against the queues
   logic [11:0] prev_a = 12'h0, prev_b = 12'h0;
   wr_t         mw;
   tr_t         mt;
   initial forever begin
      @(negedge clk);
      if (r_we) begin
         wr_cnt++;
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: addr %0h data %h", r_addr, r_data);
         end else begin
            mw = wr_q.pop_front();
            if (r_addr !== mw.addr || r_data !== mw.data) begin
               errors++;
               $display("FAIL write: got addr %0h data %h expected addr %0h data %h", r_addr, r_data, mw.addr, mw.data);
            end
         end
      end
      if (mac_valid) begin
         checks++;
         if (tr_q.size() == 0) begin
            errors++;
            $display("FAIL mac_unexpected: a_addr %0h b_addr %0h", prev_a, prev_b);
         end else begin
            mt = tr_q.pop_front();
            if ({prev_a, prev_b, mac_first, mac_last, mac_a, mac_b} !== mt) begin
               errors++;
               $display("FAIL mac_beat: got a%0h b%0h f%0b l%0b %h %h expected a%0h b%0h f%0b l%0b %h %h",
                        prev_a, prev_b, mac_first, mac_last, mac_a, mac_b, mt.a, mt.b, mt.f, mt.l, mt.ad, mt.bd);
            end
         end
      end
      if (dim_err) err_cnt++;
      prev_a = in_addr;
      prev_b = w_addr;
   end

   task automatic load_job(input int m, input int k, input int kb, input int n, output int ew, output int ee);
      tr_t t;
      wr_t w;
      int  s;
      in_mem[0] = {m[15:0], k[15:0]};
      w_mem[0]  = {kb[15:0], n[15:0]};
      for (int x = 0; x < m * k; x++) in_mem[1 + x] = i2f(a_v[x]);
      for (int x = 0; x < kb * n; x++) w_mem[1 + x] = i2f(b_v[x]);
      ee = (kb != k) ? 1 : 0;
      ew = (ee == 0 && m > 0 && k > 0 && n > 0) ? m * n : 0;
      for (int i = 0; i < m && ew > 0; i++)
         for (int j = 0; j < n; j++) begin
            s = 0;
            for (int q = 0; q < k; q++) begin
               s += a_v[i*k + q] * b_v[q*n + j];
               t.a  = 12'(1 + i*k + q);
               t.b  = 12'(1 + q*n + j);
               t.f  = q == 0;
               t.l  = q == k - 1;
               t.ad = i2f(a_v[i*k + q]);
               t.bd = i2f(b_v[q*n + j]);
               tr_q.push_back(t);
            end
            w.addr = 12'(i*n + j);
            w.data = i2f(s);
            wr_q.push_back(w);
         end
   endtask

   task automatic run_job(input int m, input int k, input int kb, input int n, input bit poke, output int cyc);
      int ew, ee, w0, e0;
      load_job(m, k, kb, n, ew, ee);
      w0 = wr_cnt;
      e0 = err_cnt;
      @(negedge clk);
      dut_valid = 1'b1;
      @(negedge clk);
      dut_valid = 1'b0;
      cyc = 0;
      while (!dut_ready && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         dut_valid = poke && cyc >= 2 && cyc <= 3;
      end
      dut_valid = 1'b0;
      chk("ready_return", 64'(dut_ready), 64'd1);
      repeat (2) @(negedge clk);
      chk("write_count", 64'(wr_cnt - w0), 64'(ew));
      chk("dim_err_count", 64'(err_cnt - e0), 64'(ee));
      chk("scoreboard_drained", 64'(wr_q.size() + tr_q.size()), 64'd0);
      wr_q.delete();
      tr_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, ew, ee, w0;
      reset_n   = 1'b0;
      dut_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_ready", 64'(dut_ready), 64'd1);
      chk("rst_we", 64'(r_we), 64'd0);
      chk("rst_addrs", 64'({in_addr, w_addr, r_addr}), 64'd0);
      chk("rst_mac", 64'({mac_valid, mac_first, mac_last, dim_err}), 64'd0);
      chk("rst_mac_data", 64'({mac_a, r_data}), 64'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_no_activity", 64'({wr_cnt[7:0], dut_ready, mac_valid}), 64'b10);

      for (int x = 0; x < 4; x++) begin
         a_v[x] = x + 1;
         b_v[x] = x + 5;
      end
      run_job(2, 2, 2, 2, 1'b0, cyc);
      chk("c00", 64'(res_mem[0]), 64'h41980000);
      chk("c01", 64'(res_mem[1]), 64'h41B00000);
      chk("c10", 64'(res_mem[2]), 64'h422C0000);
      chk("c11", 64'(res_mem[3]), 64'h42480000);

      for (int x = 0; x < 12; x++) a_v[x] = x + 1;
      for (int x = 0; x < 8; x++) b_v[x] = x + 1;
      run_job(3, 4, 4, 2, 1'b0, cyc);

      run_job(2, 3, 4, 2, 1'b0, cyc);
      chk("mismatch_ready_latency", 64'(cyc <= 3), 64'd1);

      run_job(0, 2, 2, 2, 1'b0, cyc);
      chk("zero_m_ready_latency", 64'(cyc <= 3), 64'd1);

      run_job(3, 4, 4, 2, 1'b1, cyc);
      repeat (5) @(negedge clk);
      chk("busy_poke_no_restart", 64'({dut_ready, mac_valid}), 64'b10);

      for (int x = 0; x < 16; x++) begin
         a_v[x] = x + 1;
         b_v[x] = 16 - x;
      end
      load_job(4, 4, 4, 4, ew, ee);
      w0 = wr_cnt;
      @(negedge clk);
      dut_valid = 1'b1;
      @(negedge clk);
      dut_valid = 1'b0;
      cyc = 0;
      while (!(wr_cnt - w0 >= 2 && mac_valid && !mac_last) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_mid_stream", 64'(cyc < 3000), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(dut_ready), 64'd1);
      chk("midrst_outputs", 64'({r_we, mac_valid, in_addr}), 64'd0);
      w0 = wr_cnt;
      repeat (5) @(negedge clk);
      chk("midrst_hold", 64'({dut_ready, r_we}), 64'b10);
      reset_n = 1'b1;
      wr_q.delete();
      tr_q.delete();
      repeat (3) @(negedge clk);
      chk("midrst_no_writes", 64'(wr_cnt - w0), 64'd0);
      for (int x = 0; x < 16; x++) begin
         a_v[x] = (x % 5) + 1;
         b_v[x] = (x % 3) + 2;
      end
      run_job(4, 4, 4, 4, 1'b0, cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
